// File: rtl/row_group_ctrl.sv
// row_group_ctrl: clear / MPP-write / SRAM-sweep / MISO-drain sequencer for one input-router row group.
// Optional watchdog: define ROW_GROUP_CTRL_WDT_EN to enable the FETCH/DRAIN timeout and o_error.
module row_group_ctrl #(
  parameter int ROUTER_COUNT   = 4,
  parameter int ADDR_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic [ADDR_WIDTH-1:0]   i_tile_base,
  input  logic [ADDR_WIDTH-1:0]   i_tile_len,
  input  logic [ROUTER_COUNT-1:0] i_row_count,
  input  logic                    i_addr_empty,
  input  logic                    i_data_empty,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_error,
  output logic                    o_reg_clear,
  output logic                    o_ag_en,
  output logic                    o_ag_valid,
  output logic [ROUTER_COUNT-1:0] o_row_id,
  output logic                    o_ac_en,
  output logic                    o_miso_pop_en,
  output logic                    o_sram_re,
  output logic [ADDR_WIDTH-1:0]   o_sram_addr,
  output logic [ADDR_WIDTH-1:0]   o_rg_addr,
  output logic                    o_rg_data_valid
);

  if (ROUTER_COUNT < 2) begin : g_bad_router_count
    $error("row_group_ctrl: ROUTER_COUNT must be at least 2");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("row_group_ctrl: TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_GEN, S_FETCH, S_DRAIN, S_DONE
  } state_t;

  localparam logic [ROUTER_COUNT-1:0] LP_ROWS_MAX = ROUTER_COUNT'(ROUTER_COUNT);
  localparam logic [ROUTER_COUNT-1:0] LP_ROW_ONE  = ROUTER_COUNT'(1);
  localparam logic [ADDR_WIDTH-1:0]   LP_WORD_ONE = ADDR_WIDTH'(1);

  state_t                  r_state;
  state_t                  w_next;
  logic [ADDR_WIDTH-1:0]   r_base;
  logic [ADDR_WIDTH-1:0]   r_len;
  logic [ROUTER_COUNT-1:0] r_rows;
  logic [ROUTER_COUNT-1:0] r_row;
  logic [ADDR_WIDTH-1:0]   r_word;
  logic                    r_ag_valid;
  logic [ROUTER_COUNT-1:0] r_row_id;
  logic                    r_rg_valid;
  logic [ADDR_WIDTH-1:0]   r_rg_addr;
  logic [ROUTER_COUNT-1:0] w_rows_eff;
  logic                    w_row_last;
  logic                    w_word_align;
  logic                    w_start_acc;
  logic                    w_wdt_expire;

  // Out-of-range row counts mean "all routers".
  assign w_rows_eff   = (i_row_count == '0 || i_row_count > LP_ROWS_MAX) ? LP_ROWS_MAX : i_row_count;
  assign w_row_last   = (r_row == r_rows);
  assign w_word_align = (r_word == r_len);
  assign w_start_acc  = (r_state == S_IDLE) && i_start;

`ifdef ROW_GROUP_CTRL_WDT_EN
  localparam int LP_WDT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [LP_WDT_W-1:0] LP_WDT_LAST = LP_WDT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [LP_WDT_W-1:0] LP_WDT_ONE  = LP_WDT_W'(1);

  logic [LP_WDT_W-1:0] r_wdt;
  logic                r_error;

  assign w_wdt_expire = (r_state == S_FETCH || r_state == S_DRAIN) && (r_wdt == LP_WDT_LAST);
  assign o_error      = r_error;

  // Counter is zero in every other state, so it starts from 0 on entry to FETCH.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wdt   <= '0;
      r_error <= 1'b0;
    end else begin
      if (r_state == S_FETCH || r_state == S_DRAIN) r_wdt <= r_wdt + LP_WDT_ONE;
      else                                          r_wdt <= '0;
      if (w_start_acc)       r_error <= 1'b0;
      else if (w_wdt_expire) r_error <= 1'b1;
    end
  end
`else
  assign w_wdt_expire = 1'b0;
  assign o_error      = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (i_start) w_next = S_CLEAR;
      S_CLEAR: w_next = S_GEN;
      S_GEN:   if (w_row_last) w_next = (r_len == '0) ? S_DRAIN : S_FETCH;
      S_FETCH: if (w_word_align && i_addr_empty) w_next = S_DRAIN;
      S_DRAIN: if (i_data_empty) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (w_wdt_expire) w_next = S_DONE;
  end

  always_comb begin
    o_busy        = (r_state != S_IDLE);
    o_reg_clear   = 1'b0;
    o_ag_en       = 1'b0;
    o_ac_en       = 1'b0;
    o_miso_pop_en = 1'b0;
    o_sram_re     = 1'b0;
    o_sram_addr   = '0;
    o_done        = 1'b0;
    unique case (r_state)
      S_CLEAR: o_reg_clear = 1'b1;
      S_GEN:   o_ag_en = !w_row_last;
      S_FETCH: begin
        o_ac_en   = 1'b1;
        o_sram_re = !w_word_align;
        if (!w_word_align) o_sram_addr = r_base + r_word;
      end
      S_DRAIN: o_miso_pop_en = 1'b1;
      S_DONE:  o_done = 1'b1;
      default: ;
    endcase
  end

  // Row/word counters plus the one-cycle alignment registers for the generator and comparator.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_base     <= '0;
      r_len      <= '0;
      r_rows     <= '0;
      r_row      <= '0;
      r_word     <= '0;
      r_ag_valid <= 1'b0;
      r_row_id   <= '0;
      r_rg_valid <= 1'b0;
      r_rg_addr  <= '0;
    end else begin
      if (w_start_acc) begin
        r_base <= i_tile_base;
        r_len  <= i_tile_len;
        r_rows <= w_rows_eff;
      end
      if (r_state == S_GEN && !w_row_last) r_row <= r_row + LP_ROW_ONE;
      else                                 r_row <= '0;
      // The alignment cycle wraps the word counter so a re-sweep starts from base.
      if (r_state == S_FETCH && !w_word_align) r_word <= r_word + LP_WORD_ONE;
      else                                     r_word <= '0;
      r_ag_valid <= o_ag_en;
      r_row_id   <= o_ag_en ? r_row : '0;
      r_rg_valid <= o_sram_re;
      r_rg_addr  <= o_sram_addr;
    end
  end

  assign o_ag_valid      = r_ag_valid;
  assign o_row_id        = r_row_id;
  assign o_rg_data_valid = r_rg_valid;
  assign o_rg_addr       = r_rg_addr;

endmodule
